// File: rtl/pellet_tracker.sv
// Per-frame pellet/bean collision stage feeding color_mapper: tracks alive mask, score, fright timer, level clear.
// Optional FRIGHT_WARN_EN adds the fright_warn output used to flash ghosts near the end of frightened mode.
`timescale 1ns/1ps
module pellet_tracker #(
  parameter int FIRST_POS      = 72,
  parameter int BEAN_DIST      = 96,
  parameter int MARGIN         = 2,
  parameter int SPECIAL_MARGIN = 6,
  parameter int BEAN_POINTS    = 1,
  parameter int SPECIAL_POINTS = 5,
  parameter int FRIGHT_FRAMES  = 300
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        new_game,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  output logic [23:0] bean_alive,
  output logic [3:0]  special_alive,
  output logic [6:0]  score,
  output logic        frightened,
  output logic [8:0]  fright_left,
  output logic        eat_pulse,
  output logic        level_clear
`ifdef FRIGHT_WARN_EN
  ,
  output logic        fright_warn
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [4:0]        LAST_IDX    = 5'd27;
  localparam logic [4:0]        FIRST_SPEC  = 5'd24;
  localparam logic signed [10:0] HIT_M      = 11'(MARGIN);
  localparam logic signed [10:0] SPEC_M     = 11'(SPECIAL_MARGIN);
  localparam logic [7:0]        BEAN_PTS    = 8'(BEAN_POINTS);
  localparam logic [7:0]        SPEC_PTS    = 8'(SPECIAL_POINTS);
  localparam logic [8:0]        FRIGHT_LOAD = 9'(FRIGHT_FRAMES);

  function automatic logic signed [10:0] grid(input int n);
    return 11'(FIRST_POS + BEAN_DIST * n);
  endfunction

  state_t state, next_state;

  logic sync_meta, sync_q, sync_prev, frame_tick;

  logic [4:0]         idx;
  logic signed [10:0] lat_x, lat_y;
  logic [23:0]        shadow_bean;
  logic [3:0]         shadow_special;
  logic [6:0]         shadow_score;
  logic               frame_ate, fright_load;

  logic               is_special, item_alive, bean_hit, spec_hit, hit;
  logic signed [10:0] cx, cy, dx, dy;
  logic [7:0]         pts, score_sum;
  logic [6:0]         score_inc;
  logic [8:0]         fright_next;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= frame_clk;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
    end
  end

  assign frame_tick = sync_q & ~sync_prev;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_tick) next_state = SCAN;
      SCAN:    if (idx == LAST_IDX) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (new_game) next_state = IDLE;
  end

  // Item centre for the current scan index; specials sit on the bean grid too.
  always_comb begin
    is_special = (idx >= FIRST_SPEC);
    cx = grid(int'(idx[4:2]));
    cy = grid(int'(idx[1:0]));
    if (is_special) begin
      case (idx[1:0])
        2'd0:    begin cx = grid(0); cy = grid(1); end
        2'd1:    begin cx = grid(1); cy = grid(3); end
        2'd2:    begin cx = grid(4); cy = grid(3); end
        default: begin cx = grid(5); cy = grid(1); end
      endcase
    end
  end

  assign dx = lat_x - cx;
  assign dy = lat_y - cy;

  assign bean_hit = (dx > -HIT_M) && (dx <= HIT_M) && (dy > -HIT_M) && (dy <= HIT_M);
  assign spec_hit = (dx > -SPEC_M) && (dx < SPEC_M) && (dy > -SPEC_M) && (dy < SPEC_M);

  assign item_alive = is_special ? shadow_special[idx[1:0]] : shadow_bean[idx];
  assign hit        = (state == SCAN) && item_alive && (is_special ? spec_hit : bean_hit);

  assign pts       = is_special ? SPEC_PTS : BEAN_PTS;
  assign score_sum = {1'b0, shadow_score} + pts;
  assign score_inc = (score_sum > 8'd127) ? 7'd127 : score_sum[6:0];

  // A reload in the same frame beats the decrement.
  assign fright_next = fright_load        ? FRIGHT_LOAD :
                       (fright_left != '0) ? fright_left - 9'd1 : fright_left;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx            <= '0;
      lat_x          <= '0;
      lat_y          <= '0;
      shadow_bean    <= '1;
      shadow_special <= '1;
      shadow_score   <= '0;
      frame_ate      <= 1'b0;
      fright_load    <= 1'b0;
      bean_alive     <= '1;
      special_alive  <= '1;
      score          <= '0;
      frightened     <= 1'b0;
      fright_left    <= '0;
      eat_pulse      <= 1'b0;
      level_clear    <= 1'b0;
    end else if (new_game) begin
      idx            <= '0;
      lat_x          <= '0;
      lat_y          <= '0;
      shadow_bean    <= '1;
      shadow_special <= '1;
      shadow_score   <= '0;
      frame_ate      <= 1'b0;
      fright_load    <= 1'b0;
      bean_alive     <= '1;
      special_alive  <= '1;
      score          <= '0;
      frightened     <= 1'b0;
      fright_left    <= '0;
      eat_pulse      <= 1'b0;
      level_clear    <= 1'b0;
    end else begin
      eat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            lat_x <= signed'({1'b0, BallX});
            lat_y <= signed'({1'b0, BallY});
            idx   <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            if (is_special) begin
              shadow_special[idx[1:0]] <= 1'b0;
              fright_load              <= 1'b1;
            end else begin
              shadow_bean[idx] <= 1'b0;
            end
            shadow_score <= score_inc;
            frame_ate    <= 1'b1;
          end
          idx <= idx + 5'd1;
        end
        COMMIT: begin
          bean_alive    <= shadow_bean;
          special_alive <= shadow_special;
          score         <= shadow_score;
          eat_pulse     <= frame_ate;
          fright_left   <= fright_next;
          frightened    <= (fright_next != '0);
          if (~|{shadow_bean, shadow_special}) level_clear <= 1'b1;
          frame_ate     <= 1'b0;
          fright_load   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FRIGHT_WARN_EN
  assign fright_warn = frightened && (fright_left < 9'd64) && fright_left[3];
`endif

endmodule
